dm_access_ctrl: RTL and testbench

//  MEM-stage sequencer for data memory with variable-latency req/ack handshake.

---
 rtl/dm_access_ctrl_pkg.sv | 77 +++++++
 rtl/dm_access_ctrl_load_extend.sv | 29 ++
 rtl/dm_access_ctrl.sv | 126 ++++++++++++
 tb/tb_dm_access_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_access_ctrl_pkg.sv
// Shared types and decode helpers for the MEM-stage data memory sequencer.
package dm_access_ctrl_pkg;

    localparam int unsigned INSTR_W = 6;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BE_W    = 4;

    localparam logic [INSTR_W-1:0] INSTR_LB = 6'h20;
    localparam logic [INSTR_W-1:0] INSTR_LH = 6'h21;
    localparam logic [INSTR_W-1:0] INSTR_LW = 6'h23;
    localparam logic [INSTR_W-1:0] INSTR_SB = 6'h28;
    localparam logic [INSTR_W-1:0] INSTR_SH = 6'h29;
    localparam logic [INSTR_W-1:0] INSTR_SW = 6'h2b;

    typedef enum logic [1:0] {
        DMC_IDLE = 2'd0,
        DMC_BUSY = 2'd1,
        DMC_DONE = 2'd2
    } dmc_state_e;

    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dm_req_t;

    function automatic logic is_load(input logic [INSTR_W-1:0] instr);
        return (instr == INSTR_LW) || (instr == INSTR_LH) || (instr == INSTR_LB);
    endfunction

    function automatic logic is_store(input logic [INSTR_W-1:0] instr);
        return (instr == INSTR_SW) || (instr == INSTR_SH) || (instr == INSTR_SB);
    endfunction

    // Word accesses need both low bits clear, halves only bit 0; bytes always pass.
    function automatic logic addr_aligned(input logic [INSTR_W-1:0] instr,
                                          input logic [1:0]         lo);
        logic ok;
        case (instr)
            INSTR_LW, INSTR_SW: ok = (lo == 2'b00);
            INSTR_LH, INSTR_SH: ok = ~lo[0];
            default:            ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Byte enables and lane-replicated write data for one access.
    function automatic dm_req_t build_req(input logic [INSTR_W-1:0] instr,
                                          input logic [DATA_W-1:0]  addr,
                                          input logic [DATA_W-1:0]  data);
        dm_req_t r;
        r.we    = 1'b0;
        r.be    = 4'b1111;
        r.addr  = {addr[DATA_W-1:2], 2'b00};
        r.wdata = '0;
        case (instr)
            INSTR_SW: begin
                r.we    = 1'b1;
                r.wdata = data;
            end
            INSTR_SH: begin
                r.we    = 1'b1;
                r.be    = addr[1] ? 4'b1100 : 4'b0011;
                r.wdata = {2{data[15:0]}};
            end
            INSTR_SB: begin
                r.we    = 1'b1;
                r.be    = 4'b0001 << addr[1:0];
                r.wdata = {4{data[7:0]}};
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_access_ctrl_load_extend.sv
// Selects the addressed half/byte of a read word and sign-extends it.
module dm_access_ctrl_load_extend
    import dm_access_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0]  rdata,
    input  logic [1:0]         addr_lo,
    input  logic [INSTR_W-1:0] instr,
    output logic [DATA_W-1:0]  data
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        case (instr)
            INSTR_LH: data = {{16{half_sel[15]}}, half_sel};
            INSTR_LB: data = {{24{byte_sel[7]}}, byte_sel};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/dm_access_ctrl.sv
// MEM-stage data memory sequencer: decodes, aligns and issues one req/ack access,
// stalling the pipeline until the memory answers or the wait budget runs out.
module dm_access_ctrl
    import dm_access_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_valid,
    input  logic [INSTR_W-1:0]  mem_instr,
    input  logic [DATA_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic                flush,
    output logic                stall,
    output logic [DATA_W-1:0]   ld_data,
    output logic                adel,
    output logic                ades,
    output logic                bus_err,
    output logic                dm_req,
    output logic                dm_we,
    output logic [BE_W-1:0]     dm_be,
    output logic [DATA_W-1:0]   dm_addr,
    output logic [DATA_W-1:0]   dm_wdata,
    input  logic                dm_ack,
    input  logic [DATA_W-1:0]   dm_rdata
);

    localparam int unsigned     CNT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

    dmc_state_e         state;
    logic [INSTR_W-1:0] instr_q;
    logic [1:0]         addr_lo_q;
    logic               kill;
    logic [CNT_W-1:0]   wait_cnt;

    logic               is_ld;
    logic               is_st;
    logic               aligned;
    logic               go;
    logic               killed;
    logic               timeout;
    dm_req_t            req_next;
    logic [DATA_W-1:0]  ext_data;

    assign is_ld    = is_load(mem_instr);
    assign is_st    = is_store(mem_instr);
    assign aligned  = addr_aligned(mem_instr, mem_addr[1:0]);
    assign go       = mem_valid & (is_ld | is_st) & aligned & ~flush;
    assign adel     = mem_valid & is_ld & ~aligned;
    assign ades     = mem_valid & is_st & ~aligned;
    assign stall    = ((state == DMC_IDLE) & go) | (state == DMC_BUSY);
    assign req_next = build_req(mem_instr, mem_addr, mem_wdata);
    // A flush in the ack/timeout cycle itself must also suppress DONE.
    assign killed   = kill | flush;
    assign timeout  = (MAX_WAIT != 0) && (wait_cnt == CNT_LAST) && !dm_ack;

    dm_access_ctrl_load_extend u_load_extend (
        .rdata   (dm_rdata),
        .addr_lo (addr_lo_q),
        .instr   (instr_q),
        .data    (ext_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= DMC_IDLE;
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_be     <= '0;
            dm_addr   <= '0;
            dm_wdata  <= '0;
            ld_data   <= '0;
            bus_err   <= 1'b0;
            instr_q   <= '0;
            addr_lo_q <= '0;
            kill      <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                DMC_IDLE: begin
                    if (go) begin
                        dm_req    <= 1'b1;
                        dm_we     <= req_next.we;
                        dm_be     <= req_next.be;
                        dm_addr   <= req_next.addr;
                        dm_wdata  <= req_next.wdata;
                        instr_q   <= mem_instr;
                        addr_lo_q <= mem_addr[1:0];
                        kill      <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= DMC_BUSY;
                    end
                end
                DMC_BUSY: begin
                    // Request fields stay frozen; only completion or timeout ends the access.
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (flush) kill <= 1'b1;
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        if (killed) begin
                            state <= DMC_IDLE;
                        end else begin
                            ld_data <= dm_we ? '0 : ext_data;
                            state   <= DMC_DONE;
                        end
                    end else if (timeout) begin
                        dm_req <= 1'b0;
                        if (killed) begin
                            state <= DMC_IDLE;
                        end else begin
                            bus_err <= 1'b1;
                            ld_data <= '0;
                            state   <= DMC_DONE;
                        end
                    end
                end
                DMC_DONE: state <= DMC_IDLE;
                default:  state <= DMC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl; expected request/completion records are queued
// as each access is driven and retired when the DUT issues and completes it.
module tb_dm_access_ctrl;
    import dm_access_ctrl_pkg::*;

    localparam int unsigned MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic [5:0]  mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        flush;
    logic        stall;
    logic [31:0] ld_data;
    logic        adel;
    logic        ades;
    logic        bus_err;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ld;
        logic        err;
        logic        done;
        int          nstall;
        int          nreq;
    } exp_t;

    exp_t exp_q[$];

    dm_access_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .flush     (flush),
        .stall     (stall),
        .ld_data   (ld_data),
        .adel      (adel),
        .ades      (ades),
        .bus_err   (bus_err),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_be     (dm_be),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ack    (dm_ack),
        .dm_rdata  (dm_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] ld,
                                input logic err, input logic done, input int ns, input int nr);
        exp_t e;
        e.we = we; e.be = be; e.addr = addr; e.wdata = wdata; e.ld = ld;
        e.err = err; e.done = done; e.nstall = ns; e.nreq = nr;
        return e;
    endfunction

    // One access from IDLE: ack_at/flush_at index BUSY cycles (-1 = never).
    task automatic access(input logic [5:0] instr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int ack_at, input int flush_at, input exp_t e);
        exp_t        x;
        int          n_stall;
        int          n_req;
        logic [31:0] ld_before;
        ld_before = ld_data;
        exp_q.push_back(e);
        mem_valid = 1'b1;
        mem_instr = instr;
        mem_addr  = addr;
        mem_wdata = wdata;
        #1;
        n_stall = int'(stall);
        n_req   = 0;
        x       = e;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (i == 0) x = exp_q.pop_front();
            if (!dm_req) break;
            n_req++;
            check("req_ctl", 64'({dm_we, dm_be, dm_addr}), 64'({x.we, x.be, x.addr}));
            if (x.we) check("req_wdata", 64'(dm_wdata), 64'(x.wdata));
            flush    = (i == flush_at);
            dm_ack   = (i == ack_at);
            dm_rdata = (i == ack_at) ? rdata : 32'hdead_beef;
            #1;
            n_stall += int'(stall);
        end
        mem_valid = 1'b0;
        flush     = 1'b0;
        dm_ack    = 1'b0;
        #1;
        check("busy_bound", 64'(dm_req), 64'(0));
        check("req_cycles", 64'(n_req), 64'(x.nreq));
        check("stall_cycles", 64'(n_stall), 64'(x.nstall));
        check("stall_release", 64'(stall), 64'(0));
        if (x.done) begin
            check("ld_data", 64'(ld_data), 64'(x.ld));
            check("bus_err", 64'(bus_err), 64'(x.err));
            tick();
            check("bus_err_clear", 64'(bus_err), 64'(0));
        end else begin
            check("kill_no_err", 64'(bus_err), 64'(0));
            if (ack_at >= 0) check("kill_ld_keep", 64'(ld_data), 64'(ld_before));
        end
    endtask

    // Access that must be refused: no stall, no request.
    task automatic refused(input string tag, input logic [5:0] instr, input logic [31:0] addr,
                           input logic fl, input logic exp_adel, input logic exp_ades);
        mem_valid = 1'b1;
        mem_instr = instr;
        mem_addr  = addr;
        mem_wdata = 32'h1234_5678;
        flush     = fl;
        #1;
        check({tag, "_adel"}, 64'(adel), 64'(exp_adel));
        check({tag, "_ades"}, 64'(ades), 64'(exp_ades));
        check({tag, "_stall"}, 64'(stall), 64'(0));
        tick();
        check({tag, "_noreq"}, 64'({dm_req, stall}), 64'(0));
        mem_valid = 1'b0;
        flush     = 1'b0;
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_instr = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        flush     = 1'b0;
        dm_ack    = 1'b0;
        dm_rdata  = '0;
        tick();
        tick();
        check("rst_req", 64'({dm_req, dm_we, dm_be, bus_err, stall}), 64'(0));
        check("rst_addr", 64'(dm_addr), 64'(0));
        check("rst_wdata", 64'(dm_wdata), 64'(0));
        check("rst_ld", 64'(ld_data), 64'(0));
        reset = 1'b0;
        tick();

        access(INSTR_LB, 32'h0000_1003, 32'h0, 32'h80ff_1234, 1, -1,
               mk(1'b0, 4'b1111, 32'h0000_1000, 32'h0, 32'hffff_ff80, 1'b0, 1'b1, 3, 2));
        access(INSTR_SH, 32'h0000_2002, 32'h0000_abcd, 32'h1234_5678, 2, -1,
               mk(1'b1, 4'b1100, 32'h0000_2000, 32'habcd_abcd, 32'h0, 1'b0, 1'b1, 4, 3));
        access(INSTR_LH, 32'h0000_0002, 32'h0, 32'h8001_7fff, 0, -1,
               mk(1'b0, 4'b1111, 32'h0000_0000, 32'h0, 32'hffff_8001, 1'b0, 1'b1, 2, 1));
        access(INSTR_LH, 32'h0000_0000, 32'h0, 32'h8001_7fff, 0, -1,
               mk(1'b0, 4'b1111, 32'h0000_0000, 32'h0, 32'h0000_7fff, 1'b0, 1'b1, 2, 1));
        access(INSTR_LB, 32'h0000_0001, 32'h0, 32'h80ff_1234, 0, -1,
               mk(1'b0, 4'b1111, 32'h0000_0000, 32'h0, 32'h0000_0012, 1'b0, 1'b1, 2, 1));
        access(INSTR_SB, 32'h0000_0102, 32'h1234_56a5, 32'h1234_5678, 1, -1,
               mk(1'b1, 4'b0100, 32'h0000_0100, 32'ha5a5_a5a5, 32'h0, 1'b0, 1'b1, 3, 2));
        access(INSTR_SW, 32'h0000_0008, 32'h1122_3344, 32'h1234_5678, 0, -1,
               mk(1'b1, 4'b1111, 32'h0000_0008, 32'h1122_3344, 32'h0, 1'b0, 1'b1, 2, 1));
        access(INSTR_SH, 32'h0000_0000, 32'hffff_1234, 32'h1234_5678, 0, -1,
               mk(1'b1, 4'b0011, 32'h0000_0000, 32'h1234_1234, 32'h0, 1'b0, 1'b1, 2, 1));

        refused("lw_mis", INSTR_LW, 32'h0000_0006, 1'b0, 1'b1, 1'b0);
        refused("sh_mis", INSTR_SH, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        refused("lh_mis", INSTR_LH, 32'h0000_0003, 1'b0, 1'b1, 1'b0);
        refused("non_mem", 6'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        refused("idle_flush", INSTR_LW, 32'h0000_0040, 1'b1, 1'b0, 1'b0);

        access(INSTR_LW, 32'h0000_0004, 32'h0, 32'hcafe_f00d, 2, -1,
               mk(1'b0, 4'b1111, 32'h0000_0004, 32'h0, 32'hcafe_f00d, 1'b0, 1'b1, 4, 3));
        // No ack: request held for the full wait budget, then bus_err with zero data.
        access(INSTR_LW, 32'h0000_0010, 32'h0, 32'h0, -1, -1,
               mk(1'b0, 4'b1111, 32'h0000_0010, 32'h0, 32'h0, 1'b1, 1'b1, 5, 4));
        access(INSTR_LW, 32'h0000_0020, 32'h0, 32'h5555_aaaa, 3, 1,
               mk(1'b0, 4'b1111, 32'h0000_0020, 32'h0, 32'h0, 1'b0, 1'b0, 5, 4));
        access(INSTR_LW, 32'h0000_0004, 32'h0, 32'hcafe_f00d, 0, -1,
               mk(1'b0, 4'b1111, 32'h0000_0004, 32'h0, 32'hcafe_f00d, 1'b0, 1'b1, 2, 1));
        access(INSTR_SW, 32'h0000_0030, 32'h0bad_0bad, 32'h0, -1, 0,
               mk(1'b1, 4'b1111, 32'h0000_0030, 32'h0bad_0bad, 32'h0, 1'b0, 1'b0, 5, 4));
        check("kill_to_ld_keep", 64'(ld_data), 64'(32'hcafe_f00d));

        // Reset during BUSY, then a late ack that must be ignored.
        mem_valid = 1'b1;
        mem_instr = INSTR_LW;
        mem_addr  = 32'h0000_0044;
        tick();
        check("mid_busy_req", 64'({dm_req, stall}), 64'(2'b11));
        tick();
        reset     = 1'b1;
        mem_valid = 1'b0;
        tick();
        check("mid_rst_req", 64'({dm_req, dm_we, dm_be, bus_err, stall}), 64'(0));
        check("mid_rst_addr", 64'(dm_addr), 64'(0));
        check("mid_rst_ld", 64'(ld_data), 64'(0));
        reset    = 1'b0;
        dm_ack   = 1'b1;
        dm_rdata = 32'h7777_7777;
        tick();
        dm_ack = 1'b0;
        #1;
        check("late_ack_req", 64'({dm_req, stall, bus_err}), 64'(0));
        tick();
        check("late_ack_ld", 64'(ld_data), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
